// File: rtl/score_display_if.sv
// Point inputs from the game state machine and the seven-segment / game-status outputs.
// master = game side driving points and newGame, slave = score_display.
interface score_display_if;
  logic       player1score;
  logic       player2score;
  logic       newGame;
  logic [3:0] sevenSegmentDigit;
  logic [6:0] sevenSegmentData;
  logic       gameOver;
  logic       winner;

  modport master (
    output player1score, player2score, newGame,
    input  sevenSegmentDigit, sevenSegmentData, gameOver, winner
  );

  modport slave (
    input  player1score, player2score, newGame,
    output sevenSegmentDigit, sevenSegmentData, gameOver, winner
  );
endinterface

// File: rtl/score_display.sv
// Two-player BCD scorekeeper with win detection, scanned onto a 4-digit seven-segment display.
// Latency: score +1 one edge after a point edge, gameOver one edge later, glyph one edge after score.
// No backpressure; SCORE_LEADING_ZERO_BLANK_EN blanks a tens digit of 0.
module score_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int WIN_SCORE   = 11
) (
  input logic          clk,
  input logic          rst,
  score_display_if.slave bus
);

  localparam int             CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  TERM    = CW'(REFRESH_DIV - 1);
  localparam logic [7:0]     WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_ZERO = 1'b1;
`else
  localparam bit BLANK_ZERO = 1'b0;
`endif

  logic [7:0]    p1Score, p2Score;   // {tens, ones}
  logic          p1Prev, p2Prev;
  logic [CW-1:0] refreshCnt;
  logic [1:0]    digitIdx;
  logic [3:0]    digitReg;
  logic [6:0]    segReg;
  logic          gameOverReg, winnerReg;

  logic          p1Edge, p2Edge, p1Hit, p2Hit;
  logic [1:0]    idxNext;
  logic [3:0]    digitVal, digNext;
  logic          isTens;
  logic [6:0]    segNext;

  function automatic logic [7:0] bcdInc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99)             r = s;
    else if (s[3:0] == 4'd9)    r = {s[7:4] + 4'd1, 4'd0};
    else                        r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign p1Edge = bus.player1score & ~p1Prev;
  assign p2Edge = bus.player2score & ~p2Prev;
  assign p1Hit  = (p1Score == WIN_BCD);
  assign p2Hit  = (p2Score == WIN_BCD);

  // Enable and glyph are computed for the index the scan is about to enter so both land together.
  always_comb begin
    idxNext  = digitIdx;
    if (refreshCnt == TERM) idxNext = digitIdx + 2'd1;
    digitVal = p2Score[3:0];
    isTens   = 1'b0;
    digNext  = 4'b1110;
    case (idxNext)
      2'd0: begin digitVal = p2Score[3:0]; isTens = 1'b0; digNext = 4'b1110; end
      2'd1: begin digitVal = p2Score[7:4]; isTens = 1'b1; digNext = 4'b1101; end
      2'd2: begin digitVal = p1Score[3:0]; isTens = 1'b0; digNext = 4'b1011; end
      2'd3: begin digitVal = p1Score[7:4]; isTens = 1'b1; digNext = 4'b0111; end
    endcase
    segNext = decode(digitVal);
    if (BLANK_ZERO && isTens && digitVal == 4'd0) segNext = 7'b1111111;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p1Score     <= 8'h00;
      p2Score     <= 8'h00;
      p1Prev      <= 1'b0;
      p2Prev      <= 1'b0;
      refreshCnt  <= '0;
      digitIdx    <= 2'd0;
      digitReg    <= 4'b1110;
      segReg      <= 7'b1000000;
      gameOverReg <= 1'b0;
      winnerReg   <= 1'b0;
    end else begin
      p1Prev     <= bus.player1score;
      p2Prev     <= bus.player2score;
      refreshCnt <= (refreshCnt == TERM) ? '0 : refreshCnt + CW'(1);
      digitIdx   <= idxNext;
      digitReg   <= digNext;
      segReg     <= segNext;
      if (bus.newGame) begin
        p1Score     <= 8'h00;
        p2Score     <= 8'h00;
        gameOverReg <= 1'b0;
        winnerReg   <= 1'b0;
      end else if (!gameOverReg) begin
        if (p1Edge) p1Score <= bcdInc(p1Score);
        if (p2Edge) p2Score <= bcdInc(p2Score);
        // Player 1 takes priority when both hit the winning score together.
        if (p1Hit || p2Hit) begin
          gameOverReg <= 1'b1;
          winnerReg   <= ~p1Hit;
        end
      end
    end
  end

  assign bus.sevenSegmentDigit = digitReg;
  assign bus.sevenSegmentData  = segReg;
  assign bus.gameOver          = gameOverReg;
  assign bus.winner            = winnerReg;

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display (REFRESH_DIV=4, WIN_SCORE=11): vector table, directed corners, random run vs model.
module tb_score_display;

  localparam int RDIV = 4;
  localparam int WIN  = 11;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TENS_ZERO = 7'b1111111;
`else
  localparam logic [6:0] TENS_ZERO = 7'b1000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  score_display_if bus ();

  score_display #(.REFRESH_DIV(RDIV), .WIN_SCORE(WIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain integer scores and a free-running tick count since reset.
  int  mP1, mP2, mShown1, mShown2, mT;
  bit  mPrev1, mPrev2, mGo, mWin;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int curIdx();
    return (mT / RDIV) % 4;
  endfunction

  function automatic logic [3:0] expDigit();
    logic [3:0] e;
    e = 4'b1111;
    e[curIdx()] = 1'b0;
    return e;
  endfunction

  function automatic logic [6:0] expData();
    case (curIdx())
      0: return glyph(mShown2 % 10);
      1: return (mShown2 / 10 == 0) ? TENS_ZERO : glyph(mShown2 / 10);
      2: return glyph(mShown1 % 10);
      default: return (mShown1 / 10 == 0) ? TENS_ZERO : glyph(mShown1 / 10);
    endcase
  endfunction

  task automatic modelStep();
    bit e1, e2, h1, h2;
    if (rst) begin
      mP1 = 0; mP2 = 0; mShown1 = 0; mShown2 = 0; mT = 0;
      mPrev1 = 0; mPrev2 = 0; mGo = 0; mWin = 0;
    end else begin
      e1 = bus.player1score && !mPrev1;
      e2 = bus.player2score && !mPrev2;
      h1 = (mP1 == WIN);
      h2 = (mP2 == WIN);
      mShown1 = mP1;
      mShown2 = mP2;
      if (bus.newGame) begin
        mP1 = 0; mP2 = 0; mGo = 0; mWin = 0;
      end else if (!mGo) begin
        if (e1) mP1 = (mP1 >= 99) ? 99 : mP1 + 1;
        if (e2) mP2 = (mP2 >= 99) ? 99 : mP2 + 1;
        if (h1 || h2) begin
          mGo  = 1;
          mWin = !h1;
        end
      end
      mPrev1 = bus.player1score;
      mPrev2 = bus.player2score;
      mT++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    chk("model.digit", 32'(bus.sevenSegmentDigit), 32'(expDigit()));
    chk("model.data",  32'(bus.sevenSegmentData),  32'(expData()));
    chk("model.gameOver", 32'(bus.gameOver), 32'(mGo));
    chk("model.winner",   32'(bus.winner),   32'(mWin));
  endtask

  task automatic waitIdx(input int k);
    for (int i = 0; i < 40 && curIdx() != k; i++) tick();
    chk("waitIdx.reached", 32'(curIdx()), 32'(k));
  endtask

  task automatic pulse(input bit a, input bit b);
    bus.player1score = a;
    bus.player2score = b;
    tick();
    bus.player1score = 1'b0;
    bus.player2score = 1'b0;
    tick();
  endtask

  typedef struct {
    bit         in1;
    bit         in2;
    logic [3:0] dig;
    logic [6:0] data;
  } scanVec_t;

  scanVec_t scanTab[5];

  initial begin
    scanTab[0] = '{in1: 1'b0, in2: 1'b0, dig: 4'b1110, data: 7'b1000000};
    scanTab[1] = '{in1: 1'b0, in2: 1'b0, dig: 4'b1101, data: TENS_ZERO};
    scanTab[2] = '{in1: 1'b0, in2: 1'b0, dig: 4'b1011, data: 7'b1000000};
    scanTab[3] = '{in1: 1'b0, in2: 1'b0, dig: 4'b0111, data: TENS_ZERO};
    scanTab[4] = '{in1: 1'b0, in2: 1'b0, dig: 4'b1110, data: 7'b1000000};

    bus.player1score = 1'b0;
    bus.player2score = 1'b0;
    bus.newGame      = 1'b0;

    // Reset and scan sequence after release
    rst = 1'b1;
    tick();
    tick();
    chk("reset.digit", 32'(bus.sevenSegmentDigit), 32'(4'b1110));
    chk("reset.data",  32'(bus.sevenSegmentData),  32'(7'b1000000));
    chk("reset.gameOver", 32'(bus.gameOver), 0);
    chk("reset.winner",   32'(bus.winner),   0);
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < RDIV; c++) begin
        if (p == 0 && c == 0) continue;  // reset edge already covered cycle 0 of phase 0
        bus.player1score = scanTab[p].in1;
        bus.player2score = scanTab[p].in2;
        tick();
        chk("scan.digit", 32'(bus.sevenSegmentDigit), 32'(scanTab[p].dig));
        chk("scan.data",  32'(bus.sevenSegmentData),  32'(scanTab[p].data));
      end
    end

    // Player 1 held high: one point only
    bus.player1score = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.player1score = 1'b0;
    tick();
    waitIdx(2);
    chk("hold.p1ones", 32'(bus.sevenSegmentData), 32'(7'b1111001));
    waitIdx(3);
    chk("hold.p1tens", 32'(bus.sevenSegmentData), 32'(TENS_ZERO));

    // Player 2 BCD carry 9 -> 10
    for (int i = 0; i < 9; i++) pulse(1'b0, 1'b1);
    waitIdx(0);
    chk("carry.p2ones9", 32'(bus.sevenSegmentData), 32'(7'b0010000));
    pulse(1'b0, 1'b1);
    waitIdx(0);
    chk("carry.p2ones0", 32'(bus.sevenSegmentData), 32'(7'b1000000));
    waitIdx(1);
    chk("carry.p2tens1", 32'(bus.sevenSegmentData), 32'(7'b1111001));

    // Simultaneous edges at 10/10 -> 11/11, player 1 wins
    for (int i = 0; i < 9; i++) pulse(1'b1, 1'b0);
    bus.player1score = 1'b1;
    bus.player2score = 1'b1;
    tick();
    chk("tie.gameOverLate", 32'(bus.gameOver), 0);
    tick();
    chk("tie.gameOver", 32'(bus.gameOver), 1);
    chk("tie.winner",   32'(bus.winner),   0);
    bus.player1score = 1'b0;
    bus.player2score = 1'b0;
    tick();
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    waitIdx(2);
    chk("frozen.p1ones", 32'(bus.sevenSegmentData), 32'(7'b1111001));
    waitIdx(3);
    chk("frozen.p1tens", 32'(bus.sevenSegmentData), 32'(7'b1111001));
    waitIdx(0);
    chk("frozen.p2ones", 32'(bus.sevenSegmentData), 32'(7'b1111001));

    // Player 2 wins, then newGame coinciding with a player 1 edge
    bus.newGame = 1'b1;
    tick();
    bus.newGame = 1'b0;
    chk("newGame.clear", 32'(bus.gameOver), 0);
    for (int i = 0; i < 11; i++) pulse(1'b0, 1'b1);
    chk("p2win.gameOver", 32'(bus.gameOver), 1);
    chk("p2win.winner",   32'(bus.winner),   1);
    bus.newGame      = 1'b1;
    bus.player1score = 1'b1;
    tick();
    bus.newGame      = 1'b0;
    bus.player1score = 1'b0;
    chk("ngEdge.gameOver", 32'(bus.gameOver), 0);
    chk("ngEdge.winner",   32'(bus.winner),   0);
    waitIdx(2);
    chk("ngEdge.p1dropped", 32'(bus.sevenSegmentData), 32'(7'b1000000));

    // Reset mid-scan at index 2 with scores 05/07
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) pulse(1'b0, 1'b1);
    waitIdx(2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midRst.digit", 32'(bus.sevenSegmentDigit), 32'(4'b1110));
    chk("midRst.data",  32'(bus.sevenSegmentData),  32'(7'b1000000));
    chk("midRst.gameOver", 32'(bus.gameOver), 0);
    for (int i = 0; i < RDIV; i++) tick();
    chk("midRst.scanRestart", 32'(bus.sevenSegmentDigit), 32'(4'b1101));
    waitIdx(2);
    chk("midRst.p1cleared", 32'(bus.sevenSegmentData), 32'(7'b1000000));

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) bus.player1score = ~bus.player1score;
      if ($urandom_range(0, 2) == 0) bus.player2score = ~bus.player2score;
      bus.newGame = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 799) == 0);
      tick();
    end
    rst = 1'b0;
    bus.newGame = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Sits downstream of the game state machine and beside the LED serial sender.
- Consumes the per-player point indications `player1score` and `player2score` from the game state machine.
- Keeps two-digit BCD scores for each player and detects a win.
- Time-multiplexes the four scores digits onto the board's 4-digit seven-segment display.

Parameters:
- REFRESH_DIV, 50000: clk cycles each digit is held before the scan advances. Range 2..2^20.
- WIN_SCORE, 11: score (binary value, 1..99) at which the game ends.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous reset, active-high
- player1score  input  1  point indication for player 1 from game SM; level, may stay high several cycles
- player2score  input  1  point indication for player 2 from game SM; same rules as player1score
- newGame  input  1  synchronous clear of scores and gameOver; keeps scan running
- sevenSegmentDigit  output  4  digit enables, active-low, one-hot-zero
- sevenSegmentData  output  7  segments, active-low; bit0=a … bit6=g
- gameOver  output  1  high once either player reaches WIN_SCORE
- winner  output  1  0 = player 1 won, 1 = player 2 won; valid only while gameOver=1

Behaviour:
- Reset (rst=1 at a clock edge):
  - p1 and p2 scores = 00; edge-detect registers = 0.
  - Refresh counter = 0; digit index = 0.
  - sevenSegmentDigit = 4'b1110; sevenSegmentData = 7'b1000000 (glyph "0").
  - gameOver = 0; winner = 0.
  - rst has priority over every other input, including mid-scan and mid-point.
- Point detection: rising edge only. A point counts in cycle N when input=1 at N and the input was 0 at N-1. The score register shows +1 after edge N+1. A held-high input scores once.
- Score arithmetic: per player, ones and tens are BCD.
  - Ones 9 → 0 with tens +1.
  - 99 saturates (no wrap).
- Simultaneous rising edges on both inputs: both players increment in the same cycle.
- Win detection, registered:
  - gameOver sets the cycle after a score becomes equal to WIN_SCORE.
  - winner = 0 if p1 reached WIN_SCORE, otherwise 1.
  - Both players reaching WIN_SCORE in the same cycle: winner = 0 (player 1 priority).
- While gameOver=1, point edges are ignored; scores freeze.
- newGame=1 (rst=0):
  - Next edge: scores = 00, gameOver = 0, winner = 0; edge detectors still load the current inputs.
  - Scan counter and digit index are unaffected.
  - newGame and a point edge in the same cycle: newGame wins and the point is dropped.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1.
  - At terminal count it returns to 0 and the digit index advances 0→1→2→3→0.
- Digit mapping:
  - index0 = p2 ones, enable 4'b1110
  - index1 = p2 tens, enable 4'b1101
  - index2 = p1 ones, enable 4'b1011
  - index3 = p1 tens, enable 4'b0111
- sevenSegmentDigit and sevenSegmentData are registered together; both change on the same edge as the digit index. No ghost cycle is allowed in which the enable and the data disagree.
- Decoder, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Score change while its digit is active: the new glyph appears one cycle after the score register updates.

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN.
- Defined: when a player's tens digit is 0, that tens position drives sevenSegmentData = 7'b1111111 (blank). The digit enable still scans normally.
- Undefined: tens digit 0 is shown as "0".
- Scores, gameOver, winner and scan timing are identical in both builds.

Test Plan (all with REFRESH_DIV=4):
- Reset release → sevenSegmentDigit=1110, sevenSegmentData=1000000. Digit enable then advances every 4 cycles: 1101, 1011, 0111, 1110.
- player1score held high 10 cycles → p1 = 01 (one point only). Index2 shows 1111001; index3 shows 1000000, or 1111111 with SCORE_LEADING_ZERO_BLANK_EN.
- 9 separate pulses to player2, then 1 more → p2 ones 9 then 0, tens 1. Index0 = 1000000, index1 = 1111001.
- Both inputs rise in the same cycle, with p1=10 and p2=10 → both = 11. Next cycle gameOver=1, winner=0. Further pulses leave scores at 11.
- Game over with winner=1, then newGame pulse coinciding with a player1score rising edge → next cycle scores 00, gameOver=0, winner=0. The point is not counted and the scan phase is uninterrupted.
- rst asserted mid-scan at index2 with scores 05/07 → next edge all outputs at their reset values; scan restarts at index0.
